// File: rtl/ofmap_reader_pkg.sv
// Shared defaults and FSM encoding for the output feature-map reader.
package ofmap_reader_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_NUM_MULT        = 4;
  localparam int DEF_POOL_ADDR_WIDTH = 10;
  localparam int DEF_OFMAP_DEPTH     = 784;
  localparam int DEF_RD_LATENCY      = 2;
  localparam int DEF_FIFO_DEPTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Each read fetches two words per memory (port A even, port B odd).
  function automatic int num_reads(input int depth);
    return (depth + 1) / 2;
  endfunction

endpackage

// File: rtl/ofmap_reader_if.sv
// Valid/ready beat stream from the ofmap reader to the next layer.
interface ofmap_reader_if
  import ofmap_reader_pkg::*;
#(
  parameter int W = 2 * DEF_DATA_WIDTH * DEF_NUM_MULT
);
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ofmap_skid_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on dout
// whenever empty is low.
module ofmap_skid_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ofmap_reader.sv
// Drains the conv output memories through both RAM ports after the layer
// finishes and presents {q_b_all, q_a_all} beats as a valid/ready stream.
module ofmap_reader
  import ofmap_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int NUM_MULT        = DEF_NUM_MULT,
  parameter int POOL_ADDR_WIDTH = DEF_POOL_ADDR_WIDTH,
  parameter int OFMAP_DEPTH     = DEF_OFMAP_DEPTH,
  parameter int RD_LATENCY      = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  output logic [POOL_ADDR_WIDTH-1:0]     address_a_t_use_out,
  output logic [POOL_ADDR_WIDTH-1:0]     address_b_t_use_out,
  output logic                           rden_a_use_out,
  output logic                           rden_b_use_out,
  output logic                           wren_a_use_out,
  output logic                           wren_b_use_out,
  input  logic [DATA_WIDTH*NUM_MULT-1:0] q_a_all,
  input  logic [DATA_WIDTH*NUM_MULT-1:0] q_b_all,
  ofmap_reader_if.master                 ostr,
  output logic                           busy,
  output logic                           done
);

  localparam int QW     = DATA_WIDTH * NUM_MULT;
  localparam int FW     = 2 * QW + 1;
  localparam int IW     = POOL_ADDR_WIDTH - 1;   // read index; address = 2*idx (+1)
  localparam int NREADS = num_reads(OFMAP_DEPTH);
  localparam bit ODD    = (OFMAP_DEPTH % 2) == 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        rd_idx;
  logic                 issue, final_rd, b_en, room, pipe_busy;
  logic [RD_LATENCY-1:0] vld_pipe, last_pipe, bv_pipe;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [FW-1:0]        fifo_din, fifo_dout;
  logic [QW-1:0]        q_b_gated;
  int                   occ;

  // Credit: every issued read owns a FIFO slot until it is popped, so
  // counting in-flight reads plus stored beats makes overflow impossible.
  always_comb begin
    occ = int'(fifo_count);
    for (int i = 0; i < RD_LATENCY; i++) occ = occ + (vld_pipe[i] ? 1 : 0);
  end

  assign room      = !fifo_full && (occ < FIFO_DEPTH);
  assign final_rd  = (rd_idx == IW'(NREADS - 1));
  assign b_en      = !(ODD && final_rd);
  assign pipe_busy = |vld_pipe;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; DRAIN may leave on the very cycle the last beat pops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (issue && final_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (!pipe_busy && (fifo_empty || (fifo_count == CW'(1) && fifo_pop)))
                  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_READ:  begin busy = 1'b1; issue = room; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  assign rden_a_use_out      = issue;
  assign rden_b_use_out      = issue & b_en;
  assign wren_a_use_out      = 1'b0;
  assign wren_b_use_out      = 1'b0;
  // Odd tail read keeps port B on the even address with its enable low.
  assign address_a_t_use_out = issue ? {rd_idx, 1'b0} : '0;
  assign address_b_t_use_out = issue ? {rd_idx, b_en} : '0;

  // Read index and in-flight tracking (valid, last-beat and B-valid tags).
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_idx    <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      bv_pipe   <= '0;
    end else begin
      if (state_q == ST_IDLE && start) rd_idx <= '0;
      else if (issue)                  rd_idx <= rd_idx + 1'b1;
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue & final_rd;
      bv_pipe[0]   <= issue & b_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        bv_pipe[i]   <= bv_pipe[i-1];
      end
    end
  end

  // Data lands the same cycle its tag reaches the pipe end.
  assign q_b_gated = bv_pipe[RD_LATENCY-1] ? q_b_all : '0;
  assign fifo_push = vld_pipe[RD_LATENCY-1];
  assign fifo_din  = {last_pipe[RD_LATENCY-1], q_b_gated, q_a_all};
  assign fifo_pop  = ostr.out_valid & ostr.out_ready;

  ofmap_skid_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read as zero while the FIFO is empty so reset leaves them at 0.
  assign ostr.out_valid = ~fifo_empty;
  assign ostr.out_data  = fifo_empty ? '0 : fifo_dout[2*QW-1:0];
  assign ostr.out_last  = ~fifo_empty & fifo_dout[FW-1];

endmodule

// File: tb/tb_ofmap_reader.sv
// Bench for ofmap_reader: four instances at different map depths, each with a
// two-stage registered RAM model holding word 16*m+addr in memory m.
module tb_ofmap_reader;
  import ofmap_reader_pkg::*;

  localparam int NI = 4;
  localparam int DW = 8;
  localparam int NM = 4;
  localparam int AW = 10;
  localparam int QW = DW * NM;
  localparam int W  = 2 * QW;
  localparam int FD = 4;

  function automatic int depth_of(input int i);
    case (i)
      0:       return 8;
      1:       return 5;
      2:       return 16;
      default: return 1;
    endcase
  endfunction

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t sb [$];
  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start [NI];
  logic ready [NI];
  logic [AW-1:0] addr_a [NI];
  logic [AW-1:0] addr_b [NI];
  logic rden_a [NI], rden_b [NI], wren_a [NI], wren_b [NI];
  logic busy [NI], done [NI];
  logic [QW-1:0] q_a [NI];
  logic [QW-1:0] q_b [NI];
  logic [W-1:0] odata [NI];
  logic ovalid [NI], olast [NI], ovf [NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ofmap_reader_if #(.W(W)) ostr ();
    logic [AW-1:0] ra_q = '0;
    logic [AW-1:0] rb_q = '0;
    logic [QW-1:0] qa_q = '0;
    logic [QW-1:0] qb_q = '0;

    assign ostr.out_ready = ready[g];
    assign odata[g]  = ostr.out_data;
    assign ovalid[g] = ostr.out_valid;
    assign olast[g]  = ostr.out_last;
    assign q_a[g]    = qa_q;
    assign q_b[g]    = qb_q;
    assign ovf[g]    = u_dut.fifo_push & u_dut.fifo_full;

    ofmap_reader #(
      .DATA_WIDTH(DW), .NUM_MULT(NM), .POOL_ADDR_WIDTH(AW),
      .OFMAP_DEPTH(depth_of(g)), .RD_LATENCY(2), .FIFO_DEPTH(FD)
    ) u_dut (
      .clock               (clock),
      .reset               (reset),
      .start               (start[g]),
      .address_a_t_use_out (addr_a[g]),
      .address_b_t_use_out (addr_b[g]),
      .rden_a_use_out      (rden_a[g]),
      .rden_b_use_out      (rden_b[g]),
      .wren_a_use_out      (wren_a[g]),
      .wren_b_use_out      (wren_b[g]),
      .q_a_all             (q_a[g]),
      .q_b_all             (q_b[g]),
      .ostr                (ostr),
      .busy                (busy[g]),
      .done                (done[g])
    );

    // Registered address then registered data: q valid two cycles after issue.
    always @(posedge clock) begin
      ra_q <= addr_a[g];
      rb_q <= addr_b[g];
      for (int m = 0; m < NM; m++) begin
        qa_q[m*DW +: DW] <= DW'(16 * m + int'(ra_q));
        qb_q[m*DW +: DW] <= DW'(16 * m + int'(rb_q));
      end
    end
  end

  function automatic beat_t exp_beat(input int depth, input int k);
    beat_t b;
    int nr;
    nr  = (depth + 1) / 2;
    b.d = '0;
    for (int m = 0; m < NM; m++) begin
      b.d[m*DW +: DW] = DW'(16 * m + 2 * k);
      if (2 * k + 1 < depth) b.d[QW + m*DW +: DW] = DW'(16 * m + 2 * k + 1);
    end
    b.l = (k == nr - 1);
    return b;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Queue the expected beats, then pulse start for one cycle.
  task automatic start_map(input int sel);
    int nr;
    nr = (depth_of(sel) + 1) / 2;
    for (int k = 0; k < nr; k++) sb.push_back(exp_beat(depth_of(sel), k));
    start[sel] = 1'b1;
    next_cycle();
    start[sel] = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start[0] = 1'b1;
    next_cycle();
    next_cycle();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({addr_a[i], addr_b[i], rden_a[i], rden_b[i], wren_a[i], wren_b[i],
           ovalid[i], olast[i], odata[i], busy[i], done[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d got busy=%b done=%b valid=%b rden=%b%b data=%h expected all 0",
                 i, busy[i], done[i], ovalid[i], rden_a[i], rden_b[i], odata[i]);
      end
    end
    reset    = 1'b0;
    start[0] = 1'b0;
    next_cycle();
    checks++;
    if (busy[0] !== 1'b0 || rden_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_with_reset got busy=%b rden_a=%b expected 0/0", busy[0], rden_a[0]);
    end
  endtask

  task automatic test_basic();
    int s, nb, ndone, prev_c, last_c, done_c;
    bit consec;
    beat_t e;
    s = 0; nb = 0; ndone = 0; prev_c = -1; last_c = -1; done_c = -1; consec = 1;
    ready[s] = 1'b1;
    start_map(s);
    checks++;
    if (rden_a[s] !== 1'b1 || rden_b[s] !== 1'b1 || addr_a[s] !== AW'(0) || addr_b[s] !== AW'(1)) begin
      errors++;
      $display("FAIL basic_read0 got rden=%b%b addr=%0d/%0d expected 11 0/1",
               rden_a[s], rden_b[s], addr_a[s], addr_b[s]);
    end
    for (int c = 0; c < 30; c++) begin
      if (done[s]) begin ndone++; done_c = c; end
      if (ovalid[s] && ready[s]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL basic_extra_beat got %h expected none", odata[s]);
        end else begin
          e = sb.pop_front();
          if ({odata[s], olast[s]} !== e) begin
            errors++;
            $display("FAIL basic_beat%0d got %h/%b expected %h/%b", nb, odata[s], olast[s], e.d, e.l);
          end
        end
        if (nb > 0 && c != prev_c + 1) consec = 0;
        prev_c = c;
        if (olast[s]) last_c = c;
        nb++;
      end
      next_cycle();
    end
    checks++;
    if (nb != 4 || !consec) begin
      errors++; $display("FAIL basic_count got %0d beats consec=%0d expected 4 consec=1", nb, consec);
    end
    checks++;
    if (ndone != 1 || done_c != last_c + 1) begin
      errors++;
      $display("FAIL basic_done got %0d pulses at %0d (last at %0d) expected 1 at last+1", ndone, done_c, last_c);
    end
    checks++;
    if (busy[s] !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL basic_end got busy=%b pending=%0d expected 0/0", busy[s], sb.size());
    end
    sb.delete();
  endtask

  // Covers the odd-depth tail on both depth 5 and depth 1.
  task automatic test_odd(input int s);
    int nb, nreads, nlast, nbrd, ndone, fin;
    beat_t e;
    nb = 0; nreads = 0; nlast = 0; nbrd = 0; ndone = 0;
    fin = 2 * (((depth_of(s) + 1) / 2) - 1);
    ready[s] = 1'b1;
    start_map(s);
    for (int c = 0; c < 30; c++) begin
      if (done[s]) ndone++;
      if (rden_b[s]) nbrd++;
      if (rden_a[s]) begin
        nreads++;
        checks++;
        if (addr_a[s] == AW'(fin)) begin
          if (rden_b[s] !== 1'b0 || addr_b[s] !== AW'(fin)) begin
            errors++;
            $display("FAIL odd%0d_final_read got rden_b=%b addr_b=%0d expected 0/%0d",
                     depth_of(s), rden_b[s], addr_b[s], fin);
          end
        end else if (rden_b[s] !== 1'b1 || addr_b[s] !== addr_a[s] + AW'(1)) begin
          errors++;
          $display("FAIL odd%0d_read got rden_b=%b addr_b=%0d expected 1/%0d",
                   depth_of(s), rden_b[s], addr_b[s], addr_a[s] + AW'(1));
        end
      end
      if (ovalid[s] && ready[s]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL odd%0d_extra_beat got %h expected none", depth_of(s), odata[s]);
        end else begin
          e = sb.pop_front();
          if ({odata[s], olast[s]} !== e) begin
            errors++;
            $display("FAIL odd%0d_beat%0d got %h/%b expected %h/%b",
                     depth_of(s), nb, odata[s], olast[s], e.d, e.l);
          end
        end
        if (olast[s]) nlast++;
        nb++;
      end
      next_cycle();
    end
    checks++;
    if (nb != (depth_of(s) + 1) / 2 || nreads != nb || nlast != 1 || ndone != 1) begin
      errors++;
      $display("FAIL odd%0d_counts got beats=%0d reads=%0d last=%0d done=%0d expected %0d/%0d/1/1",
               depth_of(s), nb, nreads, nlast, ndone, (depth_of(s) + 1) / 2, (depth_of(s) + 1) / 2);
    end
    checks++;
    if (nbrd != nreads - 1) begin
      errors++; $display("FAIL odd%0d_rden_b got %0d expected %0d", depth_of(s), nbrd, nreads - 1);
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    int s, nb, ndone, issued, acc;
    bit stalled;
    logic [W-1:0] held_d;
    logic held_l;
    beat_t e;
    s = 2; nb = 0; ndone = 0; issued = 0; acc = 0; stalled = 0; held_d = '0; held_l = 1'b0;
    ready[s] = 1'b0;
    start_map(s);
    for (int c = 0; c < 400 && ndone == 0; c++) begin
      ready[s] = ($urandom_range(0, 99) < 30);
      if (done[s]) ndone++;
      if (stalled) begin
        checks++;
        if (ovalid[s] !== 1'b1 || odata[s] !== held_d || olast[s] !== held_l) begin
          errors++;
          $display("FAIL bp_stable got %b/%h/%b expected 1/%h/%b", ovalid[s], odata[s], olast[s], held_d, held_l);
        end
      end
      if (rden_a[s]) begin
        issued++;
        checks++;
        if (issued - acc > FD) begin
          errors++; $display("FAIL bp_outstanding got %0d expected <= %0d", issued - acc, FD);
        end
      end
      if (ovf[s]) begin
        errors++; $display("FAIL bp_fifo_overflow got push while full expected none");
      end
      if (ovalid[s] && ready[s]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra_beat got %h expected none", odata[s]);
        end else begin
          e = sb.pop_front();
          if ({odata[s], olast[s]} !== e) begin
            errors++;
            $display("FAIL bp_beat%0d got %h/%b expected %h/%b", nb, odata[s], olast[s], e.d, e.l);
          end
        end
        nb++;
        acc++;
      end
      stalled = ovalid[s] && !ready[s];
      held_d  = odata[s];
      held_l  = olast[s];
      next_cycle();
    end
    ready[s] = 1'b0;
    checks++;
    if (nb != 8 || ndone != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_counts got beats=%0d done=%0d pending=%0d expected 8/1/0", nb, ndone, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_stall_start();
    int s, nb, ndone, nreads, prev_c;
    bit consec;
    beat_t e;
    s = 2; nb = 0; ndone = 0; nreads = 0; prev_c = -1; consec = 1;
    ready[s] = 1'b0;
    start_map(s);
    for (int c = 0; c < 20; c++) begin
      if (rden_a[s]) nreads++;
      if (ovf[s]) begin
        errors++; $display("FAIL stall_fifo_overflow got push while full expected none");
      end
      next_cycle();
    end
    checks++;
    if (nreads != FD || ovalid[s] !== 1'b1) begin
      errors++; $display("FAIL stall_reads got %0d reads valid=%b expected %0d/1", nreads, ovalid[s], FD);
    end
    ready[s] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (rden_a[s]) nreads++;
      if (done[s]) ndone++;
      if (ovalid[s] && ready[s]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stall_extra_beat got %h expected none", odata[s]);
        end else begin
          e = sb.pop_front();
          if ({odata[s], olast[s]} !== e) begin
            errors++;
            $display("FAIL stall_beat%0d got %h/%b expected %h/%b", nb, odata[s], olast[s], e.d, e.l);
          end
        end
        if (c != prev_c + 1) consec = 0;
        prev_c = c;
        nb++;
      end
      next_cycle();
    end
    checks++;
    if (nb != 8 || !consec || nreads != 8 || ndone != 1) begin
      errors++;
      $display("FAIL stall_release got beats=%0d consec=%0d reads=%0d done=%0d expected 8/1/8/1",
               nb, consec, nreads, ndone);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int s, nb, ndone, nval;
    beat_t e;
    s = 2; nb = 0; ndone = 0; nval = 0;
    ready[s] = 1'b1;
    start_map(s);
    for (int c = 0; c < 30 && nb < 4; c++) begin
      if (ovalid[s] && ready[s]) begin
        checks++;
        e = sb.pop_front();
        if ({odata[s], olast[s]} !== e) begin
          errors++;
          $display("FAIL rst_pre_beat%0d got %h/%b expected %h/%b", nb, odata[s], olast[s], e.d, e.l);
        end
        nb++;
      end
      if (nb == 4) reset = 1'b1;
      next_cycle();
    end
    reset = 1'b0;
    sb.delete();
    checks++;
    if ({addr_a[s], addr_b[s], rden_a[s], rden_b[s], ovalid[s], olast[s], odata[s], busy[s], done[s]} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got busy=%b valid=%b rden=%b%b data=%h expected all 0",
               busy[s], ovalid[s], rden_a[s], rden_b[s], odata[s]);
    end
    for (int c = 0; c < 10; c++) begin
      if (done[s]) ndone++;
      if (ovalid[s]) nval++;
      next_cycle();
    end
    checks++;
    if (ndone != 0 || nval != 0) begin
      errors++; $display("FAIL rst_mid_quiet got done=%0d valid=%0d expected 0/0", ndone, nval);
    end
    nb = 0;
    start_map(s);
    for (int c = 0; c < 30; c++) begin
      if (done[s]) ndone++;
      if (ovalid[s] && ready[s]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rst_extra_beat got %h expected none", odata[s]);
        end else begin
          e = sb.pop_front();
          if ({odata[s], olast[s]} !== e) begin
            errors++;
            $display("FAIL rst_beat%0d got %h/%b expected %h/%b", nb, odata[s], olast[s], e.d, e.l);
          end
        end
        nb++;
      end
      next_cycle();
    end
    checks++;
    if (nb != 8 || ndone != 1) begin
      errors++; $display("FAIL rst_restart got beats=%0d done=%0d expected 8/1", nb, ndone);
    end
    sb.delete();
  endtask

  task automatic test_ignored_start();
    int s, nb, ndone, nwr;
    beat_t e;
    s = 2; nb = 0; ndone = 0; nwr = 0;
    ready[s] = 1'b1;
    start_map(s);
    for (int c = 0; c < 40; c++) begin
      if (c == 3) begin
        start[s] = 1'b1;
        checks++;
        if (busy[s] !== 1'b1) begin
          errors++; $display("FAIL ign_busy got %b expected 1", busy[s]);
        end
      end
      if (c == 4) start[s] = 1'b0;
      for (int i = 0; i < NI; i++) if (wren_a[i] || wren_b[i]) nwr++;
      if (done[s]) ndone++;
      if (ovalid[s] && ready[s]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL ign_extra_beat got %h expected none", odata[s]);
        end else begin
          e = sb.pop_front();
          if ({odata[s], olast[s]} !== e) begin
            errors++;
            $display("FAIL ign_beat%0d got %h/%b expected %h/%b", nb, odata[s], olast[s], e.d, e.l);
          end
        end
        nb++;
      end
      next_cycle();
    end
    checks++;
    if (nb != 8 || ndone != 1 || nwr != 0) begin
      errors++;
      $display("FAIL ign_counts got beats=%0d done=%0d wren=%0d expected 8/1/0", nb, ndone, nwr);
    end
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      ready[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_odd(1);
    test_odd(3);
    test_backpressure();
    test_stall_start();
    test_reset_mid();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
